// File: rtl/had_inj_arb_if.sv
// had_inj_arb_if: injection-port bundle between debug requesters, arbiter and IU
interface had_inj_arb_if #(parameter int NREQ = 3);
    logic                 dbg_mode;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ*32-1:0]   req_inst;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      req_err;
    logic                 inj_inst_vld;
    logic [31:0]          inj_inst;
    logic                 inj_inst_ack;
    logic                 iu_had_xx_retire;
    logic [NREQ-1:0]      owner;
    logic                 busy;
    modport master (
        output dbg_mode, req_vld, req_inst, req_lock, inj_inst_ack, iu_had_xx_retire,
        input  req_ack, req_err, inj_inst_vld, inj_inst, owner, busy
    );
    modport slave (
        input  dbg_mode, req_vld, req_inst, req_lock, inj_inst_ack, iu_had_xx_retire,
        output req_ack, req_err, inj_inst_vld, inj_inst, owner, busy
    );
endinterface

// File: rtl/had_inj_arb.sv
// had_inj_arb: round-robin arbiter/sequencer for the debug instruction-injection port
module had_inj_arb #(
    parameter int NREQ  = 3,
    parameter int TMO_W = 8
) (
    input logic          had_clk,
    input logic          hadrst,
    had_inj_arb_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RET, HOLD} state_t;
    state_t state, state_nxt;
    logic [PW-1:0] rr_ptr, rr_nxt, own_idx, own_nxt, win_idx, cand_idx;
    logic [NREQ-1:0] owner_q, owner_nxt, ack_q, ack_nxt, err_q, err_nxt, cand;
    logic vld_q, vld_nxt;
    logic [31:0] inst_q, inst_nxt;
    logic [31:0] inst_arr [NREQ];
    logic [TMO_W-1:0] tmo_q, tmo_nxt, tmo_inc;
    for (genvar i = 0; i < NREQ; i++) begin : g_inst
        assign inst_arr[i] = bus.req_inst[32*i+31:32*i];
    end
    assign tmo_inc = tmo_q + 1'b1;
    // round-robin pick starting after rr_ptr; a requester whose ack/err is pulsing still holds its old request and is skipped
    always_comb begin
        cand = bus.req_vld & ~(ack_q | err_q);
        win_idx = '0;
        cand_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (cand[cand_idx]) win_idx = cand_idx;
        end
    end
    // next-state and next registered outputs
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        own_nxt   = own_idx;
        owner_nxt = owner_q;
        ack_nxt   = '0;
        err_nxt   = '0;
        vld_nxt   = vld_q;
        inst_nxt  = inst_q;
        tmo_nxt   = tmo_q;
        case (state)
            IDLE: if (bus.dbg_mode && |cand) begin
                state_nxt = ISSUE;
                own_nxt   = win_idx;
                owner_nxt = '0;
                owner_nxt[win_idx] = 1'b1;
                inst_nxt  = inst_arr[win_idx];
                vld_nxt   = 1'b1;
            end
            ISSUE: if (bus.inj_inst_ack) begin
                state_nxt = WAIT_RET;
                vld_nxt   = 1'b0;
                tmo_nxt   = '0;
            end else if (!bus.dbg_mode) begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
                err_nxt   = owner_q;
                rr_nxt    = own_idx;
                owner_nxt = '0;
            end
            WAIT_RET: if (bus.iu_had_xx_retire) begin
                ack_nxt = owner_q;
                if (bus.req_lock[own_idx]) state_nxt = HOLD;
                else begin
                    state_nxt = IDLE;
                    rr_nxt    = own_idx;
                    owner_nxt = '0;
                end
            end else begin
                tmo_nxt = tmo_inc;
                if (&tmo_inc) begin
                    state_nxt = IDLE;
                    err_nxt   = owner_q;
                    rr_nxt    = own_idx;
                    owner_nxt = '0;
                end
            end
            HOLD: if (!bus.dbg_mode || (~|ack_q && !bus.req_vld[own_idx] && !bus.req_lock[own_idx])) begin
                state_nxt = IDLE;
                rr_nxt    = own_idx;
                owner_nxt = '0;
            end else if (~|ack_q && bus.req_vld[own_idx]) begin
                state_nxt = ISSUE;
                inst_nxt  = inst_arr[own_idx];
                vld_nxt   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // state and output registers
    always_ff @(posedge had_clk) begin
        if (hadrst) begin
            state   <= IDLE;
            rr_ptr  <= PW'(NREQ - 1);
            own_idx <= '0;
            owner_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            vld_q   <= 1'b0;
            inst_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_nxt;
            own_idx <= own_nxt;
            owner_q <= owner_nxt;
            ack_q   <= ack_nxt;
            err_q   <= err_nxt;
            vld_q   <= vld_nxt;
            inst_q  <= inst_nxt;
            tmo_q   <= tmo_nxt;
        end
    end
    assign bus.req_ack      = ack_q;
    assign bus.req_err      = err_q;
    assign bus.inj_inst_vld = vld_q;
    assign bus.inj_inst     = inst_q;
    assign bus.owner        = owner_q;
    assign bus.busy         = state != IDLE;
endmodule

// File: doc/had_inj_arb.md
Name: had_inj_arb

Overview:
- Arbiter/sequencer for the debug-mode instruction-injection port into the IU.
- Shares one injection slot between NREQ debug requesters: JTAG single-instruction register, memory-access sequencer, register-access sequencer.
- Grants round-robin and lets a requester lock the port across a multi-instruction sequence.
- Issues one instruction at a time, tracks it to retire with a timeout, and returns a per-requester ack or error.

Parameters:
NREQ, 3, number of requesters (2..8)
TMO_W, 8, retire-timeout counter width; timeout after 2^TMO_W-1 cycles without retire

Ports:
had_clk  in  1  debug clock; all state on rising edge
hadrst  in  1  synchronous active-high reset
dbg_mode  in  1  core is in debug mode; grants only while 1
req_vld  in  NREQ  per-requester instruction request; held until its ack/err
req_inst  in  NREQ*32  instruction of requester i in bits [32i+31:32i]
req_lock  in  NREQ  requester keeps ownership after retire
req_ack  out  NREQ  one-cycle pulse: owner's instruction retired
req_err  out  NREQ  one-cycle pulse: owner's instruction aborted or timed out
inj_inst_vld  out  1  injected instruction valid to IU
inj_inst  out  32  injected instruction (registered)
inj_inst_ack  in  1  IU accepted inj_inst this cycle
iu_had_xx_retire  in  1  injected instruction retired
owner  out  NREQ  one-hot current owner; 0 in IDLE
busy  out  1  state != IDLE

Behaviour:
- Reset (hadrst=1 at clock edge):
  - state=IDLE; rr_ptr=NREQ-1, so requester 0 has first priority.
  - owner=0, inj_inst_vld=0, inj_inst=0, req_ack=0, req_err=0, busy=0, tmo_cnt=0.
  - Reset mid-operation discards any in-flight instruction; no ack/err is generated.
- States: IDLE, ISSUE, WAIT_RET, HOLD.
- IDLE:
  - If dbg_mode and |req_vld: pick the first set req_vld at index rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Set owner to the winner, latch its req_inst into inj_inst, go to ISSUE.
  - inj_inst_vld is asserted the cycle after the request is seen (1-cycle latency).
- ISSUE:
  - inj_inst_vld=1; inj_inst is stable.
  - On inj_inst_ack: tmo_cnt=0, go to WAIT_RET.
  - If dbg_mode falls before ack: drop inj_inst_vld, pulse req_err[owner], rr_ptr=owner, go to IDLE.
  - iu_had_xx_retire is ignored in ISSUE.
- WAIT_RET:
  - inj_inst_vld=0.
  - On iu_had_xx_retire: pulse req_ack[owner].
    - If req_lock[owner] is 1, go to HOLD.
    - Else rr_ptr=owner, owner=0, go to IDLE.
  - Otherwise tmo_cnt increments each cycle.
    - When tmo_cnt equals all-ones with no retire: pulse req_err[owner], rr_ptr=owner, go to IDLE.
    - Retire in the same cycle as the max count: retire wins.
  - dbg_mode falling in WAIT_RET is ignored; the instruction is already in the pipeline.
- HOLD:
  - If !dbg_mode: rr_ptr=owner, go to IDLE.
  - Else if req_vld[owner]: latch req_inst[owner], go to ISSUE.
  - Else if !req_lock[owner]: rr_ptr=owner, go to IDLE.
  - Other requesters are not granted while in HOLD.
- req_ack/req_err: registered, one-hot, exactly one cycle; never both set.
- Requesters:
  - Must deassert req_vld in the cycle after their ack/err, or present the next instruction.
  - The arbiter only samples req_vld[owner] in HOLD, and only from the cycle after the ack pulse.
- req_vld changes of non-owners never disturb the current owner.
- busy is 1 in every state except IDLE.

Test Plan:
- Reset, dbg_mode=1, req_vld=3'b001, inst0=32'h00008093; ack in ISSUE cycle 1, retire 2 cycles later -> inj_inst_vld high one cycle after request, req_ack=3'b001 one-cycle pulse, return to IDLE, owner=0.
- req_vld=3'b111 held continuously, no lock, immediate ack/retire -> grant order 0,1,2,0; owner one-hot each time; each req_ack pulses once per grant.
- Owner 1 with req_lock[1]=1 issues 3 instructions (00010113, 0020a023, 00408093) while req_vld[0] stays 1 -> all three issued to requester 1 back-to-back via HOLD; requester 0 granted only after req_lock[1] drops.
- TMO_W=4, ack given, no retire -> req_err[owner] pulses exactly 15 cycles after ack, state IDLE; retire on cycle 15 instead -> req_ack, no err.
- dbg_mode dropped in ISSUE before ack -> inj_inst_vld falls next cycle, req_err pulses; dbg_mode dropped in WAIT_RET -> retire still produces req_ack.
- hadrst asserted in WAIT_RET -> next cycle all outputs 0, state IDLE; a later retire pulse produces no ack.
